// File: rtl/raycast_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// raycast_pkg : screen geometry, palette, sequencer state and column types
// Rev 1.0
// ----------------------------------------------------------------------------
package raycast_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 180;
    localparam int unsigned C_TEX_TIMEOUT = 64;

    localparam logic [7:0] C_CEIL_COLOR  = 8'h11;
    localparam logic [7:0] C_FLOOR_COLOR = 8'h22;
    localparam logic [7:0] C_FLAT_COLOR  = 8'h0F;
    localparam logic [7:0] C_ERR_COLOR   = 8'hE0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4,
        S_NEXT = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        ROW_CEIL  = 2'd0,
        ROW_FLOOR = 2'd1,
        ROW_FLAT  = 2'd2,
        ROW_TEX   = 2'd3
    } row_kind_e;

    typedef struct packed {
        logic [8:0]  hcount;
        logic [15:0] wallX;
        logic [7:0]  lineheight;
        logic [9:0]  drawstart;
        logic [3:0]  texture;
    } col_desc_t;

    // Row-major framebuffer address; the largest pixel (319,179) still fits 16 bits.
    function automatic logic [15:0] fb_addr(input logic [8:0] hcount, input logic [7:0] vcount);
        return {7'd0, hcount} + ({8'd0, vcount} * 16'(SCREEN_WIDTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/texture_column_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// texture_column_sequencer_if : descriptor, texture lookup and framebuffer bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface texture_column_sequencer_if;

    logic        desc_valid_in;
    logic        desc_ready_out;
    logic [8:0]  hcount_in;
    logic [15:0] wallX_in;
    logic [7:0]  lineheight_in;
    logic [9:0]  drawstart_in;
    logic [3:0]  texture_in;

    logic        valid_req_out;
    logic [15:0] wallX_out;
    logic [7:0]  lineheight_out;
    logic [9:0]  drawstart_out;
    logic [3:0]  texture_out;
    logic [7:0]  vcount_ray_out;
    logic [7:0]  tex_pixel_in;
    logic        valid_tex_in;

    logic [15:0] fb_addr_out;
    logic [7:0]  fb_data_out;
    logic        fb_we_out;
    logic        col_done_out;
    logic        timeout_err_out;

    modport master (
        input  desc_valid_in, hcount_in, wallX_in, lineheight_in, drawstart_in, texture_in,
        input  tex_pixel_in, valid_tex_in,
        output desc_ready_out, valid_req_out, wallX_out, lineheight_out, drawstart_out,
        output texture_out, vcount_ray_out, fb_addr_out, fb_data_out, fb_we_out,
        output col_done_out, timeout_err_out
    );

    modport slave (
        output desc_valid_in, hcount_in, wallX_in, lineheight_in, drawstart_in, texture_in,
        output tex_pixel_in, valid_tex_in,
        input  desc_ready_out, valid_req_out, wallX_out, lineheight_out, drawstart_out,
        input  texture_out, vcount_ray_out, fb_addr_out, fb_data_out, fb_we_out,
        input  col_done_out, timeout_err_out
    );

endinterface
`default_nettype wire

// File: rtl/row_classifier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// row_classifier : decides whether a row is ceiling, floor, flat or textured wall
// Rev 1.0
// ----------------------------------------------------------------------------
module row_classifier
    import raycast_pkg::*;
(
    input  wire logic [7:0] vcount_in,
    input  wire logic [9:0] drawstart_in,
    input  wire logic [7:0] lineheight_in,
    input  wire logic [3:0] texture_in,
    output row_kind_e       kind_out
);

    logic [10:0] wall_end;
    logic        above_wall;
    logic        before_end;
    logic        textured;

    // 11-bit sum so drawstart+lineheight never wraps back into the screen.
    assign wall_end   = {1'b0, drawstart_in} + {3'd0, lineheight_in};
    assign above_wall = {2'd0, vcount_in} < drawstart_in;
    assign before_end = {3'd0, vcount_in} < wall_end;
    assign textured   = (texture_in >= 4'd2) && (texture_in <= 4'd9);

    always_comb begin
        kind_out = ROW_FLOOR;
        if (above_wall) begin
            kind_out = ROW_CEIL;
        end else if (before_end) begin
            kind_out = textured ? ROW_TEX : ROW_FLAT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/texture_column_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// texture_column_sequencer : walks one column's rows, fetches wall texels, writes pixels
// Rev 1.0
// ----------------------------------------------------------------------------
module texture_column_sequencer
    import raycast_pkg::*;
#(
    parameter logic [7:0]  CEIL_COLOR  = C_CEIL_COLOR,
    parameter logic [7:0]  FLOOR_COLOR = C_FLOOR_COLOR,
    parameter logic [7:0]  FLAT_COLOR  = C_FLAT_COLOR,
    parameter logic [7:0]  ERR_COLOR   = C_ERR_COLOR,
    parameter int unsigned TEX_TIMEOUT = C_TEX_TIMEOUT
)(
    input  wire logic                  pixel_clk_in,
    input  wire logic                  rst_in,
    texture_column_sequencer_if.master seq
);

    localparam int WAIT_W = $clog2(TEX_TIMEOUT + 1);

    seq_state_e        state_q,       state_d;
    col_desc_t         desc_q,        desc_d;
    logic [7:0]        vcount_q,      vcount_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              fb_we_q,       fb_we_d;
    logic [15:0]       fb_addr_q,     fb_addr_d;
    logic [7:0]        fb_data_q,     fb_data_d;
    logic              col_done_q,    col_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic [7:0]        pixel;
    row_kind_e         row_kind;

    row_classifier u_row_classifier (
        .vcount_in     (vcount_q),
        .drawstart_in  (desc_q.drawstart),
        .lineheight_in (desc_q.lineheight),
        .texture_in    (desc_q.texture),
        .kind_out      (row_kind)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            desc_q        <= '0;
            vcount_q      <= '0;
            wait_cnt_q    <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            col_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            desc_q        <= desc_d;
            vcount_q      <= vcount_d;
            wait_cnt_q    <= wait_cnt_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            col_done_q    <= col_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        desc_d        = desc_q;
        vcount_d      = vcount_q;
        wait_cnt_d    = wait_cnt_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        col_done_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        pixel         = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (seq.desc_valid_in) begin
                    desc_d   = '{hcount:     seq.hcount_in,
                                 wallX:      seq.wallX_in,
                                 lineheight: seq.lineheight_in,
                                 drawstart:  seq.drawstart_in,
                                 texture:    seq.texture_in};
                    vcount_d = 8'd0;
                    state_d  = S_ROW;
                end
            end
            S_ROW: begin
                case (row_kind)
                    ROW_CEIL:  begin fb_we_d = 1'b1; pixel = CEIL_COLOR;  state_d = S_NEXT; end
                    ROW_FLOOR: begin fb_we_d = 1'b1; pixel = FLOOR_COLOR; state_d = S_NEXT; end
                    ROW_FLAT:  begin fb_we_d = 1'b1; pixel = FLAT_COLOR;  state_d = S_NEXT; end
                    default:   state_d = S_REQ;
                endcase
            end
            S_REQ: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A texel landing on the timeout cycle still wins.
                if (seq.valid_tex_in) begin
                    fb_we_d = 1'b1;
                    pixel   = seq.tex_pixel_in;
                    state_d = S_GAP;
                end else if (wait_cnt_q == WAIT_W'(TEX_TIMEOUT - 1)) begin
                    fb_we_d       = 1'b1;
                    pixel         = ERR_COLOR;
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (vcount_q == 8'(SCREEN_HEIGHT - 1)) begin
                    col_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    vcount_d = vcount_q + 8'd1;
                    state_d  = S_ROW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fb_we_d) begin
            fb_addr_d = fb_addr(desc_q.hcount, vcount_q);
            fb_data_d = pixel;
        end
    end

    assign seq.desc_ready_out  = (state_q == S_IDLE);
    assign seq.valid_req_out   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign seq.wallX_out       = desc_q.wallX;
    assign seq.lineheight_out  = desc_q.lineheight;
    assign seq.drawstart_out   = desc_q.drawstart;
    assign seq.texture_out     = desc_q.texture;
    assign seq.vcount_ray_out  = vcount_q;
    assign seq.fb_we_out       = fb_we_q;
    assign seq.fb_addr_out     = fb_addr_q;
    assign seq.fb_data_out     = fb_data_q;
    assign seq.col_done_out    = col_done_q;
    assign seq.timeout_err_out = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_texture_column_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_texture_column_sequencer : directed column scenarios against a texture stub
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_texture_column_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    texture_column_sequencer_if bus ();

    texture_column_sequencer dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .seq          (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          wr_cnt    = 0;
    int          req_edges = 0;
    int          done_cnt  = 0;
    logic        prev_req  = 1'b0;
    logic [15:0] last_addr = 16'd0;
    logic [7:0]  fb_mem    [0:65535];
    logic [15:0] addr_hist [0:1023];

    bit         stub_en  = 1'b1;
    int         stub_lat = 5;
    logic [7:0] stub_pix = 8'hA5;

    always @(negedge clk) begin
        if (bus.fb_we_out) begin
            fb_mem[bus.fb_addr_out]  = bus.fb_data_out;
            addr_hist[wr_cnt % 1024] = bus.fb_addr_out;
            last_addr                = bus.fb_addr_out;
            wr_cnt++;
        end
        if (bus.valid_req_out && !prev_req) req_edges++;
        prev_req = bus.valid_req_out;
        if (bus.col_done_out) done_cnt++;
    end

    // Texture lookup stub: answers stub_lat negedges after the request rises.
    initial begin
        int lat_cnt;
        lat_cnt          = 0;
        bus.valid_tex_in = 1'b0;
        bus.tex_pixel_in = 8'h00;
        forever begin
            @(negedge clk);
            bus.valid_tex_in = 1'b0;
            if (!bus.valid_req_out) begin
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (stub_en && lat_cnt == stub_lat) begin
                    bus.valid_tex_in = 1'b1;
                    bus.tex_pixel_in = stub_pix;
                end
            end
        end
    end

    function automatic logic [7:0] exp_color(input int r, input int ds, input int lh, input int tx,
                                             input logic [7:0] pix, input bit tmo);
        if (r < ds)                 return 8'h11;
        if (r >= ds + lh)           return 8'h22;
        if (tx < 2 || tx > 9)       return 8'h0F;
        return tmo ? 8'hE0 : pix;
    endfunction

    function automatic int count_bad(input int h, input int ds, input int lh, input int tx,
                                     input logic [7:0] pix, input bit tmo);
        int bad = 0;
        for (int r = 0; r < 180; r++)
            if (fb_mem[h + r * 320] !== exp_color(r, ds, lh, tx, pix, tmo)) bad++;
        return bad;
    endfunction

    task automatic start_column(input logic [8:0] h, input logic [15:0] wx, input logic [7:0] lh,
                                input logic [9:0] ds, input logic [3:0] tx);
        int n = 0;
        @(negedge clk);
        while (!bus.desc_ready_out && n < 2000) begin @(negedge clk); n++; end
        bus.hcount_in     = h;
        bus.wallX_in      = wx;
        bus.lineheight_in = lh;
        bus.drawstart_in  = ds;
        bus.texture_in    = tx;
        bus.desc_valid_in = 1'b1;
        @(negedge clk);
        bus.desc_valid_in = 1'b0;
    endtask

    task automatic run_column(input logic [8:0] h, input logic [15:0] wx, input logic [7:0] lh,
                              input logic [9:0] ds, input logic [3:0] tx, output bit ok);
        int n = 0;
        int bd = done_cnt;
        start_column(h, wx, lh, ds, tx);
        while (done_cnt == bd && n < 20000) begin @(negedge clk); n++; end
        ok = (done_cnt != bd);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.desc_valid_in = 1'b0;
        bus.hcount_in     = '0;
        bus.wallX_in      = '0;
        bus.lineheight_in = '0;
        bus.drawstart_in  = '0;
        bus.texture_in    = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.desc_ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.desc_ready_out); end
        n_cmp++; if (bus.valid_req_out !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", bus.valid_req_out); end
        n_cmp++; if (bus.fb_we_out !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", bus.fb_we_out); end
        n_cmp++; if (bus.col_done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.col_done_out); end
        n_cmp++; if (bus.timeout_err_out !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.timeout_err_out); end
        n_cmp++; if (bus.fb_addr_out !== 16'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", bus.fb_addr_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_textured;
        int bw, be, bd, bad;
        bit ok;
        stub_en = 1'b1; stub_lat = 5; stub_pix = 8'hA5;
        bw = wr_cnt; be = req_edges; bd = done_cnt;
        run_column(9'd5, 16'h1234, 8'd40, 10'd60, 4'd3, ok);
        bad = count_bad(5, 60, 40, 3, 8'hA5, 1'b0);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tex_done: column did not complete within budget"); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tex_rows: got %0d bad rows expected 0", bad); end
        n_cmp++; if (wr_cnt - bw != 180) begin n_err++; $display("FAIL tex_writes: got %0d expected 180", wr_cnt - bw); end
        n_cmp++; if (req_edges - be != 40) begin n_err++; $display("FAIL tex_req_edges: got %0d expected 40", req_edges - be); end
        n_cmp++; if (done_cnt - bd != 1) begin n_err++; $display("FAIL tex_done_pulses: got %0d expected 1", done_cnt - bd); end
        n_cmp++; if (fb_mem[5 + 99 * 320] !== 8'hA5) begin n_err++; $display("FAIL tex_row99: got %h expected a5", fb_mem[5 + 99 * 320]); end
        n_cmp++; if (fb_mem[5 + 100 * 320] !== 8'h22) begin n_err++; $display("FAIL tex_row100: got %h expected 22", fb_mem[5 + 100 * 320]); end
        n_cmp++; if (bus.wallX_out !== 16'h1234) begin n_err++; $display("FAIL tex_wallx: got %h expected 1234", bus.wallX_out); end
        n_cmp++; if (bus.timeout_err_out !== 1'b0) begin n_err++; $display("FAIL tex_no_err: got %b expected 0", bus.timeout_err_out); end
    endtask

    task automatic test_flat;
        int bw, be, bad;
        bit ok;
        bw = wr_cnt; be = req_edges;
        run_column(9'd10, 16'h0042, 8'd180, 10'd0, 4'd1, ok);
        bad = count_bad(10, 0, 180, 1, 8'h00, 1'b0);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL flat_done: column did not complete within budget"); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL flat_rows: got %0d bad rows expected 0", bad); end
        n_cmp++; if (req_edges - be != 0) begin n_err++; $display("FAIL flat_no_req: got %0d edges expected 0", req_edges - be); end
        n_cmp++; if (wr_cnt - bw != 180) begin n_err++; $display("FAIL flat_writes: got %0d expected 180", wr_cnt - bw); end
    endtask

    task automatic test_ceil_floor;
        int bad;
        bit ok;
        run_column(9'd318, 16'h0000, 8'd0, 10'd0, 4'd4, ok);
        bad = count_bad(318, 0, 0, 4, 8'h00, 1'b0);
        n_cmp++; if (!ok || bad != 0) begin n_err++; $display("FAIL floor_rows: done=%b got %0d bad rows expected 0", ok, bad); end
        n_cmp++; if (fb_mem[318] !== 8'h22) begin n_err++; $display("FAIL floor_row0: got %h expected 22", fb_mem[318]); end
        run_column(9'd319, 16'h0000, 8'd50, 10'd200, 4'd4, ok);
        bad = count_bad(319, 200, 50, 4, 8'h00, 1'b0);
        n_cmp++; if (!ok || bad != 0) begin n_err++; $display("FAIL ceil_rows: done=%b got %0d bad rows expected 0", ok, bad); end
        n_cmp++; if (last_addr !== 16'd57599) begin n_err++; $display("FAIL ceil_last_addr: got %0d expected 57599", last_addr); end
    endtask

    task automatic test_timeout;
        int bad;
        bit ok;
        stub_en = 1'b0;
        run_column(9'd7, 16'h0077, 8'd3, 10'd10, 4'd5, ok);
        bad = count_bad(7, 10, 3, 5, 8'h00, 1'b1);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_done: column did not complete within budget"); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tmo_rows: got %0d bad rows expected 0", bad); end
        n_cmp++; if (bus.timeout_err_out !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b expected 1", bus.timeout_err_out); end
        stub_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int bw, bd, n, early, bad_a, bad_b;
        bit seen_done, accepted;
        bw = wr_cnt; bd = done_cnt;
        early = 0; seen_done = 1'b0; accepted = 1'b0; n = 0;
        start_column(9'd20, 16'h0000, 8'd180, 10'd0, 4'd0);
        bus.hcount_in     = 9'd21;
        bus.lineheight_in = 8'd180;
        bus.drawstart_in  = 10'd0;
        bus.texture_in    = 4'd1;
        bus.desc_valid_in = 1'b1;
        while (!accepted && n < 5000) begin
            if (bus.col_done_out) seen_done = 1'b1;
            if (bus.desc_ready_out) begin
                if (!seen_done) early++;
                accepted = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        bus.desc_valid_in = 1'b0;
        n = 0;
        while (done_cnt < bd + 2 && n < 5000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        bad_a = count_bad(20, 0, 180, 0, 8'h00, 1'b0);
        bad_b = count_bad(21, 0, 180, 1, 8'h00, 1'b0);
        n_cmp++; if (!accepted || early != 0) begin n_err++; $display("FAIL b2b_ready: accepted=%b early=%0d expected accepted=1 early=0", accepted, early); end
        n_cmp++; if (done_cnt - bd != 2) begin n_err++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - bd); end
        n_cmp++; if (bad_a + bad_b != 0) begin n_err++; $display("FAIL b2b_rows: got %0d bad rows expected 0", bad_a + bad_b); end
        n_cmp++; if (wr_cnt - bw != 360) begin n_err++; $display("FAIL b2b_writes: got %0d expected 360", wr_cnt - bw); end
    endtask

    task automatic test_reset_mid_column;
        int bw, n, bad;
        bit ok;
        stub_en = 1'b0;
        start_column(9'd25, 16'h5555, 8'd10, 10'd0, 4'd4);
        n = 0;
        while (!bus.valid_req_out && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.valid_req_out !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b expected 0", bus.valid_req_out); end
        n_cmp++; if (bus.desc_ready_out !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", bus.desc_ready_out); end
        n_cmp++; if (bus.timeout_err_out !== 1'b0) begin n_err++; $display("FAIL rstmid_err: got %b expected 0", bus.timeout_err_out); end
        n_cmp++; if (bus.wallX_out !== 16'h0000) begin n_err++; $display("FAIL rstmid_desc: got %h expected 0000", bus.wallX_out); end
        bw = wr_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (wr_cnt != bw) begin n_err++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_cnt - bw); end
        stub_en = 1'b1; stub_lat = 2; stub_pix = 8'h3C;
        run_column(9'd30, 16'h0001, 8'd2, 10'd0, 4'd4, ok);
        bad = count_bad(30, 0, 2, 4, 8'h3C, 1'b0);
        n_cmp++; if (addr_hist[bw % 1024] !== 16'd30) begin n_err++; $display("FAIL rstmid_first_addr: got %0d expected 30", addr_hist[bw % 1024]); end
        n_cmp++; if (!ok || bad != 0) begin n_err++; $display("FAIL rstmid_rows: done=%b got %0d bad rows expected 0", ok, bad); end
        n_cmp++; if (wr_cnt - bw != 180) begin n_err++; $display("FAIL rstmid_writes: got %0d expected 180", wr_cnt - bw); end
    endtask

    initial begin
        test_reset();
        test_textured();
        test_flat();
        test_ceil_floor();
        test_timeout();
        test_back_to_back();
        test_reset_mid_column();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
